// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential unsigned shift-and-add multiplier
// One partial product (a AND one bit of b) accumulated per clock behind a start/busy/done handshake.
module seq_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [0:0]         state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  logic               b_bit;
  logic [WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0] pp_ext;
  logic [2*WIDTH-1:0] acc_next;

  // Select the current multiplier bit with a one-hot mask so no index-width games are needed.
  assign b_bit    = |(b_reg & (ONE << count));
  assign pp       = a_reg & {WIDTH{b_bit}};
  assign pp_ext   = {{WIDTH{1'b0}}, pp} << count;
  assign acc_next = acc + pp_ext;

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      product <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          // Last partial product goes straight into product so done lines up with the new value.
          if (count == LAST) begin
            product <= acc_next;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - directed self-checking bench for seq_shift_add_mult
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic        busy;
  logic        done;
  logic [7:0]  product;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int pulses;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start one WIDTH=4 multiply, wait (bounded) for done, then check latency and product.
  task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp, input string tag);
    a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_prod"}, product, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_prod", product, 0);
    rst = 1'b0;

    // 15*15 with a cycle-by-cycle view of busy/done
    a = 4'd15; b = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    a = 4'd0; b = 4'd0;
    for (int i = 0; i < 3; i++) begin
      check("ff_busy_run", busy, 1);
      check("ff_done_run", done, 0);
      step();
    end
    check("ff_busy_e3", busy, 1);
    step();
    check("ff_done_e4", done, 1);
    check("ff_busy_e4", busy, 0);
    check("ff_prod", product, 225);
    step();
    check("ff_done_e5", done, 0);
    check("ff_prod_hold", product, 225);

    run4(4'd0, 4'd13, 8'd0, "a0");
    run4(4'd13, 4'd0, 8'd0, "b0");
    run4(4'd1, 4'd1, 8'd1, "one");
    step();

    // back-to-back: second start lands in the first done cycle
    run4(4'd6, 4'd7, 8'd42, "b2b_first");
    a = 4'd9; b = 4'd11; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_cleared", done, 0);
    for (int i = 0; i < 3; i++) begin
      check("b2b_prod_hold", product, 42);
      step();
    end
    check("b2b_prod_hold_e3", product, 42);
    step();
    check("b2b_done2", done, 1);
    check("b2b_prod2", product, 99);
    step();

    // start while busy is ignored
    a = 4'd3; b = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 4'd15; b = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check("ign_lat", lat, 4);
    check("ign_prod", product, 15);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) pulses++;
    end
    check("ign_extra_done", pulses, 0);
    check("ign_prod_hold", product, 15);

    // reset on the second RUN edge aborts the multiply
    a = 4'd12; b = 4'd10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmid_busy", busy, 0);
    check("rmid_done", done, 0);
    check("rmid_prod", product, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) pulses++;
    end
    check("rmid_no_done", pulses, 0);
    run4(4'd12, 4'd10, 8'd120, "rmid_after");
    step();

    // exhaustive WIDTH=4 sweep against the bench's own product
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [7:0] e;
        e = 8'(i * j);
        run4(4'(i), 4'(j), e, "sweep");
      end
    end

    // WIDTH=8 corner
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      step();
      lat++;
    end
    check("w8_lat", lat, 8);
    check("w8_prod", product8, 65025);
    step();
    check("w8_done_low", done8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
